sqrt_residual_checker: RTL

Sequential checker on the output side of the approximate square-root units. It takes a radicand R (16 bit) and a candidate root q (8 bit). It squares q with an 8-iteration shift-add datapath and reports the square, the signed residual R − q², and classification flags. It is the inverse-direction companion to the combinational root units and is used in Sobel-magnitude error characterisation and in self-check benches.

---
 rtl/sqrt_chk_pkg.sv | 17 +
 rtl/sqrt_chk_shift_add.sv | 42 ++++
 rtl/sqrt_residual_checker.sv | 106 ++++++++++
 3 files changed

// File: rtl/sqrt_chk_pkg.sv
// Shared types and constants for the square-root residual checker:
// FSM state encoding and the fixed 16-bit radicand / 8-bit root widths.
package sqrt_chk_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      CHK  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int RAD_W  = 16;
   localparam int ROOT_W = 8;
   localparam int RES_W  = 17;
   localparam logic [2:0] ITER_LAST = 3'd7;

endpackage

// File: rtl/sqrt_chk_shift_add.sv
// Shift-add squarer datapath: one multiplier bit per step, LSB first.
// The multiplicand and the multiplier are both loaded from the root on start.
module sqrt_chk_shift_add
   import sqrt_chk_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              step,
   input  logic [ROOT_W-1:0] multiplier,
   output logic [RAD_W-1:0]  acc,
   output logic              last
);

   logic [RAD_W-1:0]  mcand;
   logic [ROOT_W-1:0] mbits;
   logic [2:0]        count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc   <= '0;
         mcand <= '0;
         mbits <= '0;
         count <= '0;
      end else if (start) begin
         acc   <= '0;
         mcand <= {{(RAD_W-ROOT_W){1'b0}}, multiplier};
         mbits <= multiplier;
         count <= '0;
      end else if (step) begin
         // 255^2 fits in 16 bits, so the sum never carries out.
         if (mbits[0])
            acc <= acc + mcand;
         mcand <= mcand << 1;
         mbits <= mbits >> 1;
         count <= count + 3'd1;
      end
   end

   assign last = (count == ITER_LAST);

endmodule

// File: rtl/sqrt_residual_checker.sv
// Squares a candidate root, forms the signed residual R - q^2 and flags
// whether q is floor(sqrt(R)), too large, or too small.
module sqrt_residual_checker
   import sqrt_chk_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [RAD_W-1:0]  radicand,
   input  logic [ROOT_W-1:0] root,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [RAD_W-1:0]  square,
   output logic [RES_W-1:0]  residual,
   output logic              floor_ok,
   output logic              root_high,
   output logic              root_low
);

   state_t            state, state_next;
   logic [RAD_W-1:0]  rad_lat;
   logic [ROOT_W-1:0] root_lat;
   logic              start, step, last;
   logic [RAD_W-1:0]  acc;
   logic [RES_W-1:0]  res_calc;
   logic              high_calc, low_calc;

   sqrt_chk_shift_add u_shift_add (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .step       (step),
      .multiplier (root),
      .acc        (acc),
      .last       (last)
   );

   assign in_ready = (state == IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      start      = 1'b0;
      step       = 1'b0;
      case (state)
         IDLE: if (in_valid) begin
            start      = 1'b1;
            state_next = MUL;
         end
         MUL: begin
            step = 1'b1;
            if (last)
               state_next = CHK;
         end
         CHK:  state_next = DONE;
         DONE: if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rad_lat  <= '0;
         root_lat <= '0;
      end else if (start) begin
         rad_lat  <= radicand;
         root_lat <= root;
      end
   end

   // Residual within [0, 2q] means q^2 <= R < (q+1)^2.
   always_comb begin
      res_calc  = {1'b0, rad_lat} - {1'b0, acc};
      high_calc = res_calc[RES_W-1];
      low_calc  = !res_calc[RES_W-1] &&
                  (res_calc[RAD_W-1:0] > {7'b0, root_lat, 1'b0});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         square    <= '0;
         residual  <= '0;
         floor_ok  <= 1'b0;
         root_high <= 1'b0;
         root_low  <= 1'b0;
      end else if (state == CHK) begin
         out_valid <= 1'b1;
         square    <= acc;
         residual  <= res_calc;
         floor_ok  <= !(high_calc | low_calc);
         root_high <= high_calc;
         root_low  <= low_calc;
      end else if (state == DONE && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
